game_screen_ctrl: RTL and testbench

Top-level screen sequencer for the VGA maze game. A frame-synchronous state machine decides which screen source (title, maze, scare image, game-over text, win) drives the 3-bit RGB output. It tracks remaining lives and times the scare interval. It also generates the cycling text colour consumed by the game-over screen. It sits between the per-screen renderers and the VGA output pins, fed by the same pixel coordinates as the renderers.

---
 rtl/game_screen_ctrl.sv | 164 ++++++++++++++++
 tb/tb_game_screen_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_screen_ctrl.sv
// Screen sequencer for the VGA maze game: picks the active screen once per frame,
// tracks lives, times the scare interval and cycles the game-over text colour.
module game_screen_ctrl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SCARE_FRAMES = 120,
  parameter int unsigned COLOR_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       start_btn,
  input  logic       collision,
  input  logic       goal,
  input  logic [2:0] rgb_title,
  input  logic [2:0] rgb_maze,
  input  logic [2:0] rgb_scare,
  input  logic [2:0] rgb_gameover,
  input  logic [2:0] rgb_win,
  output logic [2:0] rgb,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic [2:0] gameover_color
);

  localparam logic [2:0] StTitle    = 3'd0;
  localparam logic [2:0] StPlay     = 3'd1;
  localparam logic [2:0] StScare    = 3'd2;
  localparam logic [2:0] StGameover = 3'd3;
  localparam logic [2:0] StWin      = 3'd4;

  localparam logic [1:0] LivesInit = 2'(LIVES);
  localparam logic [7:0] ScareLast = 8'(SCARE_FRAMES - 1);
  localparam logic [7:0] ColorLast = 8'(COLOR_FRAMES - 1);
  localparam logic [2:0] ColorInit = 3'b001;

  logic [2:0] state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] color_cnt_q, color_cnt_d;
  logic [2:0] color_q, color_d;
  logic       pending_q, pending_d;
  logic       origin_q;
  logic       start_q;
  logic [2:0] rgb_q;
  logic [2:0] rgb_sel;

  logic at_origin;
  logic tick;
  logic start_rise;

  // Coordinates dwell several clocks per pixel, so only the first (0,0) clock is the tick.
  assign at_origin  = (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign tick       = at_origin && !origin_q;
  assign start_rise = start_btn && !start_q;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;
    color_cnt_d = color_cnt_q;
    color_d     = color_q;
    pending_d   = pending_q;
    if (tick) begin
      // Every tick consumes the pending start, whether or not the screen can use it.
      pending_d = 1'b0;
      case (state_q)
        StTitle: begin
          if (pending_q) begin
            state_d     = StPlay;
            lives_d     = LivesInit;
            frame_cnt_d = 8'd0;
          end
        end
        StPlay: begin
          if (collision) begin
            state_d     = StScare;
            lives_d     = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
            frame_cnt_d = 8'd0;
          end else if (goal) begin
            state_d = StWin;
          end
        end
        StScare: begin
          if (frame_cnt_q == ScareLast) begin
            frame_cnt_d = 8'd0;
            if (lives_q == 2'd0) begin
              state_d     = StGameover;
              color_d     = ColorInit;
              color_cnt_d = 8'd0;
            end else begin
              state_d = StPlay;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        StGameover: begin
          if (pending_q) begin
            state_d = StTitle;
          end else if (color_cnt_q == ColorLast) begin
            color_cnt_d = 8'd0;
            color_d     = (color_q == 3'b111) ? 3'b001 : color_q + 3'd1;
          end else begin
            color_cnt_d = color_cnt_q + 8'd1;
          end
        end
        StWin: begin
          if (pending_q) begin
            state_d = StTitle;
          end
        end
        default: state_d = StTitle;
      endcase
    end
    // A press landing on the tick clock is kept for the following tick.
    if (start_rise) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    rgb_sel = 3'b000;
    case (state_q)
      StTitle:    rgb_sel = rgb_title;
      StPlay:     rgb_sel = rgb_maze;
      StScare:    rgb_sel = rgb_scare;
      StGameover: rgb_sel = rgb_gameover;
      StWin:      rgb_sel = rgb_win;
      default:    rgb_sel = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StTitle;
      lives_q     <= LivesInit;
      frame_cnt_q <= 8'd0;
      color_cnt_q <= 8'd0;
      color_q     <= ColorInit;
      pending_q   <= 1'b0;
      origin_q    <= 1'b0;
      start_q     <= 1'b0;
      rgb_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      frame_cnt_q <= frame_cnt_d;
      color_cnt_q <= color_cnt_d;
      color_q     <= color_d;
      pending_q   <= pending_d;
      origin_q    <= at_origin;
      start_q     <= start_btn;
      rgb_q       <= video_on ? rgb_sel : 3'b000;
    end
  end

  assign rgb            = rgb_q;
  assign state          = state_q;
  assign lives          = lives_q;
  assign gameover_color = color_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Bench for game_screen_ctrl: scaled-down coordinate generator, scenario tasks,
// expected observations queued at stimulus time and popped when sampled.
module tb_game_screen_ctrl;

  localparam int XMAX  = 7;
  localparam int YMAX  = 3;
  localparam int HOLD  = 2;
  localparam int FRAME = (XMAX + 1) * (YMAX + 1) * HOLD;

  localparam logic [2:0] RgbTitle = 3'b001;
  localparam logic [2:0] RgbMaze  = 3'b101;
  localparam logic [2:0] RgbScare = 3'b011;
  localparam logic [2:0] RgbOver  = 3'b110;
  localparam logic [2:0] RgbWin   = 3'b010;

  logic       clk = 1'b0;
  logic       reset;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       start_btn;
  logic       collision;
  logic       goal;
  logic [2:0] rgb_title, rgb_maze, rgb_scare, rgb_gameover, rgb_win;
  logic [2:0] rgb;
  logic [2:0] state;
  logic [1:0] lives;
  logic [2:0] gameover_color;

  typedef struct {
    string       name;
    logic [10:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_num = 0;
  int   hold = 0;

  game_screen_ctrl #(
    .LIVES        (3),
    .SCARE_FRAMES (4),
    .COLOR_FRAMES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .video_on       (video_on),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .start_btn      (start_btn),
    .collision      (collision),
    .goal           (goal),
    .rgb_title      (rgb_title),
    .rgb_maze       (rgb_maze),
    .rgb_scare      (rgb_scare),
    .rgb_gameover   (rgb_gameover),
    .rgb_win        (rgb_win),
    .rgb            (rgb),
    .state          (state),
    .lives          (lives),
    .gameover_color (gameover_color)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] pk(input logic [2:0] s, input logic [1:0] l,
                                     input logic [2:0] c, input logic [2:0] r);
    return {s, l, c, r};
  endfunction

  function automatic logic [10:0] observed();
    return {state, lives, gameover_color, rgb};
  endfunction

  task automatic gen_coords();
    forever begin
      @(negedge clk);
      if (hold == HOLD - 1) begin
        hold = 0;
        if (pixel_x == 10'(XMAX)) begin
          pixel_x = 10'd0;
          pixel_y = (pixel_y == 10'(YMAX)) ? 10'd0 : pixel_y + 10'd1;
        end else begin
          pixel_x = pixel_x + 10'd1;
        end
        if (pixel_x == 10'd0 && pixel_y == 10'd0) tick_num++;
      end else begin
        hold++;
      end
    end
  endtask

  // Returns one clock after the n-th upcoming tick edge, when rgb reflects the new state.
  task automatic wait_ticks(input int n);
    int target;
    int guard;
    target = tick_num + n;
    guard  = 0;
    while (tick_num < target && guard < n * FRAME + 20) begin
      @(posedge clk);
      guard++;
    end
    if (tick_num < target) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got %0d ticks, required %0d", tick_num, target);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mid();
    int guard;
    guard = 0;
    @(posedge clk);
    while (pixel_y != 10'd2 && guard < 2 * FRAME) begin
      @(posedge clk);
      guard++;
    end
  endtask

  task automatic press_start();
    @(negedge clk);
    start_btn = 1'b1;
    repeat (3) @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    sb.push_back('{"reset_values", pk(3'd0, 2'd3, 3'b001, 3'b000)});
    repeat (3) @(posedge clk);
    #1;
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    wait_mid();
    @(negedge clk);
    reset = 1'b1;
    sb.push_back('{"title_after_release", pk(3'd0, 2'd3, 3'b001, RgbTitle)});
    repeat (3) @(posedge clk);
    #1;
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
  endtask

  task automatic test_start_mid_frame();
    exp_t e;
    wait_mid();
    press_start();
    sb.push_back('{"start_waits_for_tick", pk(3'd0, 2'd3, 3'b001, RgbTitle)});
    repeat (4) @(posedge clk);
    #1;
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    sb.push_back('{"start_to_play", pk(3'd1, 2'd3, 3'b001, RgbMaze)});
    wait_ticks(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
  endtask

  task automatic test_collision_scare();
    exp_t e;
    @(negedge clk);
    collision = 1'b1;
    sb.push_back('{"scare_entry", pk(3'd2, 2'd2, 3'b001, RgbScare)});
    wait_ticks(1);
    collision = 1'b0;
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    sb.push_back('{"scare_hold_3_ticks", pk(3'd2, 2'd2, 3'b001, RgbScare)});
    wait_ticks(3);
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    sb.push_back('{"scare_exit_4th_tick", pk(3'd1, 2'd2, 3'b001, RgbMaze)});
    wait_ticks(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
  endtask

  task automatic test_gameover();
    exp_t       e;
    logic [2:0] exp_col;
    for (int hit = 0; hit < 2; hit++) begin
      @(negedge clk);
      collision = 1'b1;
      sb.push_back('{"hit_scare", pk(3'd2, 2'(1 - hit), 3'b001, RgbScare)});
      wait_ticks(1);
      collision = 1'b0;
      e = sb.pop_front(); checks++;
      if (observed() !== e.val) begin
        errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
      end
      if (hit == 0) sb.push_back('{"hit_back_to_play", pk(3'd1, 2'd1, 3'b001, RgbMaze)});
      else sb.push_back('{"gameover_entry", pk(3'd3, 2'd0, 3'b001, RgbOver)});
      wait_ticks(4);
      e = sb.pop_front(); checks++;
      if (observed() !== e.val) begin
        errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
      end
    end
    sb.push_back('{"color_hold_1_tick", pk(3'd3, 2'd0, 3'b001, RgbOver)});
    wait_ticks(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    exp_col = 3'b010;
    sb.push_back('{"color_step", pk(3'd3, 2'd0, exp_col, RgbOver)});
    wait_ticks(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    for (int i = 0; i < 6; i++) begin
      exp_col = (exp_col == 3'b111) ? 3'b001 : exp_col + 3'd1;
      sb.push_back('{"color_cycle", pk(3'd3, 2'd0, exp_col, RgbOver)});
      wait_ticks(2);
      e = sb.pop_front(); checks++;
      if (observed() !== e.val) begin
        errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
      end
    end
    wait_mid();
    press_start();
    sb.push_back('{"gameover_to_title", pk(3'd0, 2'd0, 3'b001, RgbTitle)});
    wait_ticks(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
  endtask

  task automatic test_priority_and_win();
    exp_t e;
    wait_mid();
    press_start();
    sb.push_back('{"restart_play", pk(3'd1, 2'd3, 3'b001, RgbMaze)});
    wait_ticks(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    @(negedge clk);
    collision = 1'b1;
    goal      = 1'b1;
    sb.push_back('{"collision_beats_goal", pk(3'd2, 2'd2, 3'b001, RgbScare)});
    wait_ticks(1);
    collision = 1'b0;
    goal      = 1'b0;
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    sb.push_back('{"scare_ends", pk(3'd1, 2'd2, 3'b001, RgbMaze)});
    wait_ticks(4);
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    @(negedge clk);
    goal = 1'b1;
    sb.push_back('{"goal_to_win", pk(3'd4, 2'd2, 3'b001, RgbWin)});
    wait_ticks(1);
    goal = 1'b0;
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    wait_mid();
    press_start();
    sb.push_back('{"win_to_title", pk(3'd0, 2'd2, 3'b001, RgbTitle)});
    wait_ticks(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
  endtask

  task automatic test_reset_mid_scare();
    exp_t e;
    wait_mid();
    press_start();
    wait_ticks(1);
    @(negedge clk);
    collision = 1'b1;
    sb.push_back('{"scare_before_reset", pk(3'd2, 2'd2, 3'b001, RgbScare)});
    wait_ticks(1);
    collision = 1'b0;
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    wait_ticks(2);
    wait_mid();
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{"async_reset_mid_scare", pk(3'd0, 2'd3, 3'b001, 3'b000)});
    #1;
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    press_start();
    sb.push_back('{"tick_after_release", pk(3'd1, 2'd3, 3'b001, RgbMaze)});
    wait_ticks(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
  endtask

  task automatic test_video_blank();
    exp_t e;
    @(negedge clk);
    video_on = 1'b0;
    sb.push_back('{"blank_rgb", pk(3'd1, 2'd3, 3'b001, 3'b000)});
    @(posedge clk);
    #1;
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    @(negedge clk);
    video_on = 1'b1;
    sb.push_back('{"rgb_latency", pk(3'd1, 2'd3, 3'b001, 3'b000)});
    sb.push_back('{"unblank_rgb", pk(3'd1, 2'd3, 3'b001, RgbMaze)});
    #1;
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
    @(posedge clk);
    #1;
    e = sb.pop_front(); checks++;
    if (observed() !== e.val) begin
      errors++; $display("FAIL %s: got %b required %b", e.name, observed(), e.val);
    end
  endtask

  initial begin
    reset        = 1'b0;
    video_on     = 1'b1;
    pixel_x      = 10'd0;
    pixel_y      = 10'd0;
    start_btn    = 1'b0;
    collision    = 1'b0;
    goal         = 1'b0;
    rgb_title    = RgbTitle;
    rgb_maze     = RgbMaze;
    rgb_scare    = RgbScare;
    rgb_gameover = RgbOver;
    rgb_win      = RgbWin;
    fork
      gen_coords();
    join_none
    test_reset();
    test_start_mid_frame();
    test_collision_scare();
    test_gameover();
    test_priority_and_win();
    test_reset_mid_scare();
    test_video_blank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

endmodule
